user_mul: RTL and testbench

Sequential shift-add multiplier: the inverse arithmetic unit to `user_div`. It shares the same 20-bit operand width and `done_sig` completion style. It sits beside `user_div` in the arithmetic datapath, where it scales coordinates and sizes by integer factors. It uses one partial-product bit per clock, with fixed latency independent of operand values.

---
 rtl/user_mul_pkg.sv | 20 ++
 rtl/user_mul.sv | 106 ++++++++++
 tb/tb_user_mul.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/user_mul_pkg.sv
// rtl/user_mul_pkg.sv - shared arithmetic constants, FSM state type and counter-width helper
// Contents:
//   MUL_WIDTH   operand width shared with the divider
//   mul_state_t IDLE / RUN / DONE, 2-bit encoding
//   cnt_width   bits needed to count 0..n
package user_mul_pkg;

  localparam int MUL_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/user_mul.sv
// rtl/user_mul.sv - sequential shift-add unsigned multiplier, one partial product per clock
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         request, sampled only in IDLE
//   multiplicand  operand A, latched on accept
//   multiplier    operand B, latched on accept
//   product       registered A*B, held until the next operation completes
//   overflow      upper half of product non-zero, same timing as product
//   busy          high from the cycle after accept through the done_sig cycle
//   done_sig      one-cycle pulse marking product valid
module user_mul
  import user_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done_sig
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t           state;
  mul_state_t           state_nxt;
  logic [2*WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_reg;
  logic [CW-1:0]        cnt;
  logic                 load;
  logic                 step;
  logic                 finish;
  logic                 busy_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed WIDTH iterations, no early exit on B=0
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode. busy is registered, so it stays high for the
  // done_sig cycle too; a start seen in IDLE keeps it high back-to-back.
  always_comb begin
    load     = (state == IDLE) && start;
    step     = (state == RUN);
    finish   = (state == DONE);
    busy_nxt = (state != IDLE) || start;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done_sig <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      done_sig <= finish;
      if (load) begin
        a_reg <= {{WIDTH{1'b0}}, multiplicand};
        b_reg <= multiplier;
        acc   <= '0;
        cnt   <= '0;
      end
      if (step) begin
        if (b_reg[0]) begin
          acc <= acc + a_reg;
        end
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + CW'(1);
      end
      if (finish) begin
        product  <= acc;
        overflow <= |acc[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_user_mul.sv
// tb/tb_user_mul.sv - self-checking bench for user_mul against an arithmetic reference model
module tb_user_mul;

  localparam int W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic [2*W-1:0]   product;
  logic             overflow;
  logic             busy;
  logic             done_sig;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  user_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .overflow     (overflow),
    .busy         (busy),
    .done_sig     (done_sig)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned pa;
    longint unsigned pb;
    longint unsigned p;
    pa = a;
    pb = b;
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  function automatic logic ref_overflow(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned pa;
    longint unsigned pb;
    pa = a;
    pb = b;
    return ((pa * pb) >> W) != 0;
  endfunction

  // Issue one operation and follow it to its done pulse plus one cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt,
                        output logic done_after, output logic busy_after);
    start = 1'b1; multiplicand = a; multiplier = b;
    tick;
    start = 1'b0; multiplicand = W'($urandom); multiplier = W'($urandom);
    lat = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done_sig !== 1'b1 && lat < 100) begin
      tick;
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    tick;
    done_after = done_sig;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; multiplicand = 20'd5; multiplier = 20'd5;
    repeat (3) tick;
    vectors++; if (product !== '0) begin miscompares++; $display("FAIL reset_product got %h want 0", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_with_start got %b want 0", busy); end
    vectors++; if (done_sig !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done_sig); end
    rst = 1'b0; start = 1'b0;
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int lat, bc;
    logic da, ba;
    logic [2*W-1:0] exp;
    exp = ref_product(20'd3, 20'd10);
    run_op(20'd3, 20'd10, lat, bc, da, ba);
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL basic_latency got %0d want 21", lat); end
    vectors++; if (bc !== 22) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 22", bc); end
    vectors++; if (product !== exp) begin miscompares++; $display("FAIL basic_product got %h want %h", product, exp); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_overflow got %b want 0", overflow); end
    vectors++; if (da !== 1'b0 || ba !== 1'b0) begin miscompares++; $display("FAIL basic_after got done=%b busy=%b want 0 0", da, ba); end
    repeat (5) tick;
    vectors++; if (product !== exp) begin miscompares++; $display("FAIL basic_hold got %h want %h", product, exp); end
  endtask

  task automatic test_max;
    int lat, bc;
    logic da, ba;
    run_op(20'hFFFFF, 20'hFFFFF, lat, bc, da, ba);
    vectors++; if (product !== 40'hFFFFE00001) begin miscompares++; $display("FAIL max_product got %h want FFFFE00001", product); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL max_overflow got %b want 1", overflow); end
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL max_latency got %0d want 21", lat); end
  endtask

  task automatic test_zero;
    int lat, bc;
    logic da, ba;
    run_op(20'h12345, 20'h0, lat, bc, da, ba);
    vectors++; if (product !== '0) begin miscompares++; $display("FAIL zero_b_product got %h want 0", product); end
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL zero_b_latency got %0d want 21", lat); end
    run_op(20'h0, 20'hFFFFF, lat, bc, da, ba);
    vectors++; if (product !== '0) begin miscompares++; $display("FAIL zero_a_product got %h want 0", product); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL zero_a_overflow got %b want 0", overflow); end
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL zero_a_latency got %0d want 21", lat); end
  endtask

  task automatic test_busy_ignore;
    int n_done, first_edge, lat, bc;
    logic da, ba;
    logic [2*W-1:0] p_seen;
    n_done = 0; first_edge = -1; p_seen = '0;
    start = 1'b1; multiplicand = 20'd7; multiplier = 20'd6;
    tick;
    multiplicand = 20'd100; multiplier = 20'd100;
    for (int e = 1; e <= 30; e++) begin
      start = (e == 5 || e == 21);
      tick;
      if (done_sig === 1'b1) begin
        n_done++;
        if (first_edge < 0) begin first_edge = e; p_seen = product; end
      end
    end
    start = 1'b0;
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL busy_ignore_done_count got %0d want 1", n_done); end
    vectors++; if (first_edge !== 21) begin miscompares++; $display("FAIL busy_ignore_done_edge got %0d want 21", first_edge); end
    vectors++; if (p_seen !== ref_product(20'd7, 20'd6)) begin miscompares++; $display("FAIL busy_ignore_product got %h want %h", p_seen, ref_product(20'd7, 20'd6)); end
    vectors++; if (product !== ref_product(20'd7, 20'd6)) begin miscompares++; $display("FAIL busy_ignore_hold got %h want %h", product, ref_product(20'd7, 20'd6)); end
    run_op(20'd100, 20'd100, lat, bc, da, ba);
    vectors++; if (product !== ref_product(20'd100, 20'd100)) begin miscompares++; $display("FAIL busy_ignore_fresh got %h want %h", product, ref_product(20'd100, 20'd100)); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc;
    logic da, ba;
    logic [W-1:0] a, b;
    start = 1'b1; multiplicand = 20'hFFFFF; multiplier = 20'hFFFFF;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    vectors++; if (product !== '0 || overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_result got %h/%b want 0/0", product, overflow); end
    vectors++; if (busy !== 1'b0 || done_sig !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", busy, done_sig); end
    rst = 1'b0;
    a = W'($urandom); b = W'($urandom);
    run_op(a, b, lat, bc, da, ba);
    vectors++; if (lat !== 21) begin miscompares++; $display("FAIL midrst_restart_latency got %0d want 21", lat); end
    vectors++; if (product !== ref_product(a, b)) begin miscompares++; $display("FAIL midrst_restart_product got %h want %h", product, ref_product(a, b)); end
  endtask

  task automatic test_back_to_back;
    int n_done, d1, d2;
    logic [2*W-1:0] p1, p2;
    logic ovf2;
    n_done = 0; d1 = -1; d2 = -1; p1 = '0; p2 = '0; ovf2 = 1'bx;
    start = 1'b1; multiplicand = 20'd5; multiplier = 20'd5;
    tick;
    for (int e = 1; e <= 60 && n_done < 2; e++) begin
      tick;
      if (done_sig === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          d1 = e; p1 = product;
          multiplicand = 20'd1000; multiplier = 20'd1000;
        end else begin
          d2 = e; p2 = product; ovf2 = overflow;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    tick;
    vectors++; if (d1 !== 21) begin miscompares++; $display("FAIL b2b_first_edge got %0d want 21", d1); end
    vectors++; if (d2 !== 43) begin miscompares++; $display("FAIL b2b_second_edge got %0d want 43", d2); end
    vectors++; if (p1 !== ref_product(20'd5, 20'd5)) begin miscompares++; $display("FAIL b2b_first_product got %h want %h", p1, ref_product(20'd5, 20'd5)); end
    vectors++; if (p2 !== ref_product(20'd1000, 20'd1000)) begin miscompares++; $display("FAIL b2b_second_product got %h want %h", p2, ref_product(20'd1000, 20'd1000)); end
    vectors++; if (ovf2 !== ref_overflow(20'd1000, 20'd1000)) begin miscompares++; $display("FAIL b2b_second_overflow got %b want %b", ovf2, ref_overflow(20'd1000, 20'd1000)); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after got busy=%b want 0", busy); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic da, ba;
    logic [W-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom) >> $urandom_range(0, W - 1);
      b = W'($urandom) >> $urandom_range(0, W - 1);
      if (i == 0) begin a = 20'h80000; b = 20'd2; end
      if (i == 1) begin a = 20'd1; b = 20'hFFFFF; end
      run_op(a, b, lat, bc, da, ba);
      vectors++; if (product !== ref_product(a, b)) begin miscompares++; $display("FAIL rand_product a=%h b=%h got %h want %h", a, b, product, ref_product(a, b)); end
      vectors++; if (overflow !== ref_overflow(a, b)) begin miscompares++; $display("FAIL rand_overflow a=%h b=%h got %b want %b", a, b, overflow, ref_overflow(a, b)); end
      vectors++; if (lat !== 21 || bc !== 22) begin miscompares++; $display("FAIL rand_timing a=%h b=%h got lat=%0d busy=%0d want 21 22", a, b, lat, bc); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    test_reset;
    test_basic;
    test_max;
    test_zero;
    test_busy_ignore;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
